pwm_bank: RTL and testbench
===========================

PWM_BANK -- requirements
Module: pwm_bank

Interface
- REQ-001 SHALL have parameter NUM_CH, default 16, meaning number of PWM channels, legal range 1..16.
- REQ-002 SHALL have parameter PRESC_W, default 8, meaning prescaler counter width, legal range 1..8.
- REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is clocked on its rising edge.
- REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-005 SHALL have port wr_en, input, 1 bit: register write strobe, one write per cycle when high.
- REQ-006 SHALL have port wr_addr, input, 7 bits: register address.
- REQ-007 SHALL have port wr_data, input, 8 bits: register write data.
- REQ-008 SHALL have port out, output, NUM_CH bits: channel outputs, registered.
- REQ-009 SHALL have port period_tick, output, 1 bit: one-cycle pulse on counter wrap.

Function
- REQ-010 SHALL use this register map: 0x00 en_out[7:0]; 0x01 en_out[15:8]; 0x02 en_pwm[7:0]; 0x03 en_pwm[15:8]; 0x04 global duty; 0x05 prescale; 0x06 ctrl (bit0 per_ch_mode); 0x10+n duty of channel n.
- REQ-011 SHALL ignore writes to unmapped addresses, to 0x10+n with n>=NUM_CH, and to enable bits for channels n>=NUM_CH.
- REQ-012 SHALL assert prescaler tick for one cycle every (prescale+1) clk cycles; prescale=0 SHALL give a tick every cycle.
- REQ-013 SHALL reload the prescaler counter to 0 on any write to 0x05, with the new value governing the next tick.
- REQ-014 SHALL advance the 8-bit period counter cnt on each tick, wrapping 255->0.
- REQ-015 SHALL pulse period_tick in the same cycle cnt registers the 255->0 wrap.
- REQ-016 SHALL write duty registers (global and per-channel) into staging copies; active copies SHALL load from staging only on the wrap cycle.
- REQ-017 SHALL make a write coinciding with the wrap cycle visible in the active copy at that same wrap.
- REQ-018 SHALL compute per-channel PWM level as cnt < active duty, where the duty used is per-channel when per_ch_mode=1 and global otherwise.
- REQ-019 SHALL force the PWM level constantly high when duty=0xFF; duty=0x00 SHALL give constantly low.
- REQ-020 SHALL drive out[n] = en_out[n] AND (en_pwm[n] ? level[n] : 1), registered, giving 1 cycle latency from cnt.
- REQ-021 SHALL apply en_out, en_pwm and ctrl writes immediately, without waiting for the wrap.

Reset
- REQ-022 SHALL, on rst_n low, clear asynchronously all registers, staging and active duties, cnt, the prescaler counter, out and period_tick to 0.
- REQ-023 SHALL resume counting from cnt=0 on the first tick after rst_n deasserts; a reset mid-period SHALL discard pending staged values.

Configuration
- REQ-024 SHALL implement macro PWM_BANK_PHASE_STAGGER_EN: when defined, ctrl bit1 SHALL enable staggering, comparing channel n against (cnt + n*(256/NUM_CH rounded down)) mod 256.
- REQ-025 SHALL, without PWM_BANK_PHASE_STAGGER_EN, ignore ctrl bit1 and compare all channels against cnt directly.

Structure
- REQ-026 SHALL place register address constants, the ctrl bit positions and the 0xFF full-duty constant in shared package pwm_bank_pkg.
- REQ-027 SHALL implement the prescaler plus period counter as one sub-module, pwm_timebase, producing tick, cnt and wrap.

Verification
- REQ-028 SHALL cover: prescale=0, global duty=0x40, en_out=en_pwm=0xFFFF, per_ch_mode=0 -> every channel high 64 of 256 cycles, period_tick every 256 cycles.
- REQ-029 SHALL cover: per_ch_mode=1, duty ch0=0x00, ch1=0x80, ch2=0xFF -> ch0 always low, ch1 high 128/256, ch2 always high.
- REQ-030 SHALL cover: duty ch3 changed 0x20->0xC0 at cnt=100 -> high time changes only after the next period_tick, with no runt pulse.
- REQ-031 SHALL cover: prescale=3 -> cnt increments every 4 clocks and the period is 1024 clocks; a write to 0x05 mid-count restarts the prescaler.
- REQ-032 SHALL cover: en_pwm[5]=0 with en_out[5]=1 -> out[5] constant high; en_out[5]=0 -> out[5] low; and NUM_CH=4 with a write to 0x17 -> no state change.
- REQ-033 SHALL cover: rst_n pulsed low mid-period with staged duty pending -> all outputs 0 immediately and the staged duty lost.

Source files
------------

// File: rtl/pwm_bank_pkg.sv
// Shared register map, ctrl bit positions and duty constants for pwm_bank.
// Optional macro PWM_BANK_PHASE_STAGGER_EN is consumed by pwm_bank.sv.
package pwm_bank_pkg;

  typedef enum logic [6:0] {
    REG_EN_OUT_LO = 7'h00,
    REG_EN_OUT_HI = 7'h01,
    REG_EN_PWM_LO = 7'h02,
    REG_EN_PWM_HI = 7'h03,
    REG_GDUTY     = 7'h04,
    REG_PRESCALE  = 7'h05,
    REG_CTRL      = 7'h06,
    REG_DUTY_BASE = 7'h10
  } reg_addr_e;

  localparam int unsigned CTRL_PER_CH_BIT  = 0;
  localparam int unsigned CTRL_STAGGER_BIT = 1;

  localparam logic [7:0] FULL_DUTY = 8'hFF;
  localparam logic [7:0] CNT_MAX   = 8'hFF;

  // Full duty is pinned high so 0xFF does not leave a one-count low gap.
  function automatic logic duty_level(input logic [7:0] c, input logic [7:0] duty);
    return (duty == FULL_DUTY) || (c < duty);
  endfunction

endpackage

// File: rtl/pwm_bank_timebase.sv
// Prescaler plus 8-bit period counter; wrap marks the cycle whose edge rolls cnt 255->0.
module pwm_timebase
  import pwm_bank_pkg::*;
#(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PRESC_W-1:0] prescale,
  input  logic               presc_reload,
  output logic               tick,
  output logic [7:0]         cnt,
  output logic               wrap
);

  logic [PRESC_W-1:0] presc_cnt;

  assign tick = (presc_cnt == prescale);
  assign wrap = tick && (cnt == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_cnt <= '0;
      cnt       <= '0;
    end else begin
      if (presc_reload || tick) begin
        presc_cnt <= '0;
      end else begin
        presc_cnt <= presc_cnt + 1'b1;
      end
      if (tick) begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/pwm_bank.sv
// Bank of PWM channels sharing one timebase, with duty double-buffered to the period wrap.
// Define PWM_BANK_PHASE_STAGGER_EN to enable per-channel phase staggering via ctrl bit1.
module pwm_bank
  import pwm_bank_pkg::*;
#(
  parameter int NUM_CH  = 16,
  parameter int PRESC_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [6:0]        wr_addr,
  input  logic [7:0]        wr_data,
  output logic [NUM_CH-1:0] out,
  output logic              period_tick
);

  logic [NUM_CH-1:0]  en_out;
  logic [NUM_CH-1:0]  en_pwm;
  logic [NUM_CH-1:0]  level;
  logic [7:0]         gduty_stg;
  logic [7:0]         gduty_act;
  logic [7:0]         duty_stg [NUM_CH];
  logic [7:0]         duty_act [NUM_CH];
  logic [7:0]         cmp_cnt  [NUM_CH];
  logic [PRESC_W-1:0] prescale;
  logic               per_ch_mode;
  logic               wr_gduty;
  logic               wr_presc;
  logic [7:0]         cnt;
  logic               wrap;
  logic               tick_unused;
`ifdef PWM_BANK_PHASE_STAGGER_EN
  logic               stagger_en;
`endif

  assign wr_gduty = wr_en && (wr_addr == REG_GDUTY);
  assign wr_presc = wr_en && (wr_addr == REG_PRESCALE);

  // Everything in this level keys off wrap; the raw prescaler tick stays inside the timebase.
  pwm_timebase #(
    .PRESC_W(PRESC_W)
  ) u_timebase (
    .clk         (clk),
    .rst_n       (rst_n),
    .prescale    (prescale),
    .presc_reload(wr_presc),
    .tick        (tick_unused),
    .cnt         (cnt),
    .wrap        (wrap)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_out      <= '0;
      en_pwm      <= '0;
      gduty_stg   <= '0;
      prescale    <= '0;
      per_ch_mode <= 1'b0;
`ifdef PWM_BANK_PHASE_STAGGER_EN
      stagger_en  <= 1'b0;
`endif
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        duty_stg[n] <= '0;
      end
    end else if (wr_en) begin
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        if (wr_addr == ((n < 8) ? REG_EN_OUT_LO : REG_EN_OUT_HI)) begin
          en_out[n] <= wr_data[n[2:0]];
        end
        if (wr_addr == ((n < 8) ? REG_EN_PWM_LO : REG_EN_PWM_HI)) begin
          en_pwm[n] <= wr_data[n[2:0]];
        end
        if (wr_addr == REG_DUTY_BASE + 7'(n)) begin
          duty_stg[n] <= wr_data;
        end
      end
      if (wr_gduty) begin
        gduty_stg <= wr_data;
      end
      if (wr_presc) begin
        prescale <= wr_data[PRESC_W-1:0];
      end
      if (wr_addr == REG_CTRL) begin
        per_ch_mode <= wr_data[CTRL_PER_CH_BIT];
`ifdef PWM_BANK_PHASE_STAGGER_EN
        stagger_en  <= wr_data[CTRL_STAGGER_BIT];
`endif
      end
    end
  end

  // A write landing on the wrap cycle bypasses staging so it takes effect at this wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gduty_act   <= '0;
      out         <= '0;
      period_tick <= 1'b0;
      for (int unsigned n = 0; n < NUM_CH; n++) begin
        duty_act[n] <= '0;
      end
    end else begin
      if (wrap) begin
        gduty_act <= wr_gduty ? wr_data : gduty_stg;
        for (int unsigned n = 0; n < NUM_CH; n++) begin
          duty_act[n] <= (wr_en && (wr_addr == REG_DUTY_BASE + 7'(n))) ? wr_data : duty_stg[n];
        end
      end
      out         <= en_out & (~en_pwm | level);
      period_tick <= wrap;
    end
  end

  always_comb begin
    level = '0;
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      cmp_cnt[n] = cnt;
`ifdef PWM_BANK_PHASE_STAGGER_EN
      if (stagger_en) begin
        cmp_cnt[n] = cnt + 8'(n * (256 / NUM_CH));
      end
`endif
      level[n] = duty_level(cmp_cnt[n], per_ch_mode ? duty_act[n] : gduty_act);
    end
  end

endmodule

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank: a 16-channel instance plus a 4-channel one.
module tb_pwm_bank;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en, s_wr_en;
  logic [6:0]  wr_addr;
  logic [7:0]  wr_data;
  logic [15:0] out;
  logic        period_tick;
  logic [3:0]  s_out;
  logic        s_period_tick;

  int checks = 0;
  int fails  = 0;
  int hi [16];
  int pt;
  int h1, h2, n;
  bit got;

  always #5 clk = ~clk;

  pwm_bank #(
    .NUM_CH (16),
    .PRESC_W(8)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .out        (out),
    .period_tick(period_tick)
  );

  pwm_bank #(
    .NUM_CH (4),
    .PRESC_W(2)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (s_wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .out        (s_out),
    .period_tick(s_period_tick)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; the write is captured on the following posedge.
  task automatic wr(input bit sel, input logic [6:0] a, input logic [7:0] d);
    wr_addr = a;
    wr_data = d;
    if (sel) s_wr_en = 1'b1;
    else     wr_en   = 1'b1;
    @(negedge clk);
    wr_en   = 1'b0;
    s_wr_en = 1'b0;
  endtask

  task automatic wait_ptick(input bit sel, input int limit);
    int  k    = 0;
    bit  seen = 1'b0;
    while (!seen && k < limit) begin
      @(negedge clk);
      k++;
      seen = sel ? s_period_tick : period_tick;
    end
    if (!seen) check("ptick_timeout", 32'd0, 32'd1);
  endtask

  task automatic measure(input bit sel, input int len);
    logic [15:0] o;
    for (int ch = 0; ch < 16; ch++) hi[ch] = 0;
    pt = 0;
    repeat (len) begin
      @(negedge clk);
      o = sel ? {12'd0, s_out} : out;
      for (int ch = 0; ch < 16; ch++) hi[ch] += o[ch] ? 1 : 0;
      pt += (sel ? s_period_tick : period_tick) ? 1 : 0;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    s_wr_en = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_ptick", {31'd0, period_tick}, 32'd0);
    check("rst_small_out", {28'd0, s_out}, 32'd0);
    rst_n = 1'b1;

    // Global mode, duty 0x40, prescale 0
    wr(0, 7'h00, 8'hFF);
    wr(0, 7'h01, 8'hFF);
    wr(0, 7'h02, 8'hFF);
    wr(0, 7'h03, 8'hFF);
    wr(0, 7'h04, 8'h40);
    wait_ptick(0, 600);
    measure(0, 256);
    for (int ch = 0; ch < 16; ch++) check($sformatf("global_hi_ch%0d", ch), hi[ch], 64);
    check("global_ptick_per_256", pt, 1);

    // Per-channel mode
    wr(0, 7'h10, 8'h00);
    wr(0, 7'h11, 8'h80);
    wr(0, 7'h12, 8'hFF);
    wr(0, 7'h13, 8'h20);
    wr(0, 7'h06, 8'h01);
    wait_ptick(0, 300);
    measure(0, 256);
    check("perch_ch0_zero", hi[0], 0);
    check("perch_ch1_half", hi[1], 128);
    check("perch_ch2_full", hi[2], 256);
    check("perch_ch3", hi[3], 32);
    check("perch_ch4_unset", hi[4], 0);
    check("perch_ptick", pt, 1);

    // ch3 duty 0x20 -> 0xC0 written at cnt=100
    wait_ptick(0, 300);
    h1 = 0;
    h2 = 0;
    for (int i = 1; i <= 512; i++) begin
      @(negedge clk);
      if (i <= 256) h1 += out[3] ? 1 : 0;
      else          h2 += out[3] ? 1 : 0;
      if (i == 100) begin
        wr_addr = 7'h13;
        wr_data = 8'hC0;
        wr_en   = 1'b1;
      end else if (i == 101) begin
        wr_en = 1'b0;
      end
    end
    check("stage_old_period", h1, 32);
    check("stage_new_period", h2, 192);

    // Enable gating on channel 5
    wr(0, 7'h02, 8'hDF);
    wait_ptick(0, 300);
    measure(0, 256);
    check("ch5_pwm_off_high", hi[5], 256);
    check("ch4_pwm_on", hi[4], 0);
    wr(0, 7'h00, 8'hDF);
    wait_ptick(0, 300);
    measure(0, 256);
    check("ch5_out_off_low", hi[5], 0);
    check("ch3_new_duty", hi[3], 192);

    // NUM_CH=4: writes beyond the channel range are dropped
    wr(1, 7'h00, 8'hFF);
    wr(1, 7'h02, 8'hFF);
    wr(1, 7'h06, 8'h01);
    wr(1, 7'h13, 8'h40);
    wait_ptick(1, 600);
    measure(1, 256);
    check("small_ch3", hi[3], 64);
    check("small_ptick", pt, 1);
    wr(1, 7'h17, 8'hC0);
    wait_ptick(1, 300);
    measure(1, 256);
    check("small_0x17_ch3", hi[3], 64);
    check("small_0x17_others", hi[0] + hi[1] + hi[2], 0);

    // Prescale 3, global duty 1
    wr(0, 7'h06, 8'h00);
    wr(0, 7'h04, 8'h01);
    wr(0, 7'h00, 8'hFF);
    wr(0, 7'h02, 8'hFF);
    wr(0, 7'h05, 8'h03);
    wait_ptick(0, 1100);
    measure(0, 1024);
    check("presc3_ch0", hi[0], 4);
    check("presc3_ch5", hi[5], 4);
    check("presc3_ch15", hi[15], 4);
    check("presc3_ptick_per_1024", pt, 1);

    // Prescaler restart one cycle into the period delays the wrap by one clock
    wait_ptick(0, 1100);
    wr(0, 7'h05, 8'h03);
    n   = 1;
    got = 1'b0;
    while (!got && n < 1100) begin
      @(negedge clk);
      n++;
      got = period_tick;
    end
    check("presc_restart_period", n, 1025);

    // Reset mid-period with a staged global duty pending
    wr(0, 7'h05, 8'h00);
    wr(0, 7'h02, 8'h00);
    wr(0, 7'h03, 8'h00);
    @(negedge clk);
    check("pre_reset_out", {16'd0, out}, 32'h0000FFFF);
    wr(0, 7'h04, 8'h80);
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {16'd0, out}, 32'd0);
    check("async_rst_ptick", {31'd0, period_tick}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wr(0, 7'h00, 8'hFF);
    wr(0, 7'h01, 8'hFF);
    wr(0, 7'h02, 8'hFF);
    wr(0, 7'h03, 8'hFF);
    n   = 4;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      got = period_tick;
    end
    check("post_reset_first_wrap", n, 256);
    measure(0, 256);
    check("staged_lost_ch0", hi[0], 0);
    check("staged_lost_ch9", hi[9], 0);
    check("post_reset_ptick", pt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
